// File: rtl/sdram_port_arbiter_if.sv
// Port bundle for sdram_port_arbiter: two requester ports, the SDRAM controller port and status.
// The slave view belongs to the arbiter; the master view belongs to whatever surrounds it.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [15:0]       m0_wdata;
  logic              m0_ack;
  logic [15:0]       m0_rdata;

  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [15:0]       m1_wdata;
  logic              m1_ack;
  logic [15:0]       m1_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_ack;
  logic [15:0]       mem_rdata;
  logic              refresh_busy;

  logic [1:0]        grant;
  logic              timeout_err;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    output m0_ack, m0_rdata,
    input  m1_req, m1_wr, m1_addr, m1_wdata,
    output m1_ack, m1_rdata,
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata, refresh_busy,
    output grant, timeout_err
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    input  m0_ack, m0_rdata,
    output m1_req, m1_wr, m1_addr, m1_wdata,
    input  m1_ack, m1_rdata,
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output mem_ack, mem_rdata, refresh_busy,
    input  grant, timeout_err
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller between the UART host path (m0) and the
// FX2 slave-FIFO path (m1), with a per-transfer watchdog that aborts a stuck controller.
module sdram_port_arbiter #(
  parameter int ADDR_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  sdram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

  state_t            r_state;
  // Last-served requester; it also names the current owner from grant until DONE.
  logic              r_last_m1;
  logic [15:0]       r_cnt;
  logic [1:0]        r_grant;
  logic [1:0]        r_ack;
  logic [15:0]       r_rdata [2];
  logic              r_mem_req;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_mem_wdata;
  logic              r_timeout_err;

  logic [1:0]        w_req;
  logic              w_win_m1;
  logic              w_win_wr;
  logic [ADDR_W-1:0] w_win_addr;
  logic [15:0]       w_win_wdata;
  logic [15:0]       w_cnt_inc;
  logic              w_cnt_hit;

  assign w_req = {bus.m1_req, bus.m0_req};
  // m1 wins when it is alone, or when both ask and m0 was served last.
  assign w_win_m1    = w_req[1] & (~w_req[0] | ~r_last_m1);
  assign w_win_wr    = w_win_m1 ? bus.m1_wr    : bus.m0_wr;
  assign w_win_addr  = w_win_m1 ? bus.m1_addr  : bus.m0_addr;
  assign w_win_wdata = w_win_m1 ? bus.m1_wdata : bus.m0_wdata;

  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_cnt_hit = (w_cnt_inc == LP_TIMEOUT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= ST_IDLE;
      r_last_m1     <= 1'b1;
      r_cnt         <= '0;
      r_grant       <= '0;
      r_ack         <= '0;
      r_rdata[0]    <= '0;
      r_rdata[1]    <= '0;
      r_mem_req     <= 1'b0;
      r_mem_wr      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!bus.refresh_busy && (|w_req)) begin
            r_state     <= ST_BUSY;
            r_last_m1   <= w_win_m1;
            r_grant     <= w_win_m1 ? 2'b10 : 2'b01;
            r_mem_req   <= 1'b1;
            r_mem_wr    <= w_win_wr;
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
            r_cnt       <= '0;
          end
        end
        ST_BUSY: begin
          r_cnt <= w_cnt_inc;
          // A late ack in the watchdog's final cycle still counts as a normal completion.
          if (bus.mem_ack) begin
            r_state            <= ST_DONE;
            r_mem_req          <= 1'b0;
            r_ack[r_last_m1]   <= 1'b1;
            r_rdata[r_last_m1] <= bus.mem_rdata;
          end else if (w_cnt_hit) begin
            r_state            <= ST_DONE;
            r_mem_req          <= 1'b0;
            r_ack[r_last_m1]   <= 1'b1;
            r_rdata[r_last_m1] <= '0;
            r_timeout_err      <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_ack      <= '0;
          r_rdata[0] <= '0;
          r_rdata[1] <= '0;
          r_grant    <= '0;
          r_cnt      <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.m0_ack      = r_ack[0];
  assign bus.m0_rdata    = r_rdata[0];
  assign bus.m1_ack      = r_ack[1];
  assign bus.m1_rdata    = r_rdata[1];
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_wr      = r_mem_wr;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.grant       = r_grant;
  assign bus.timeout_err = r_timeout_err;

endmodule
